// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and transfer status between a requester and ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    // Requester side: offers a byte and watches the transfer outcome.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout_err
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits with odd
// parity and stop bit clocked out on device clock falls, then device ACK check.
// Pads are open-drain; this block only produces the active "drive low" enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned START_HOLD     = 200,
    parameter int unsigned FILTER_CYCLES  = 19,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         kclk_in,
    input  logic         kdata_in,
    output logic         kclk_drive_low,
    output logic         kdata_drive_low
);

    localparam int unsigned PhaseMax = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES
                                                                     : START_HOLD;
    localparam int unsigned PhaseW = $clog2(PhaseMax + 1);
    localparam int unsigned ToW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FiltW  = $clog2(FILTER_CYCLES + 1);

    localparam logic [PhaseW-1:0] InhibitLast = PhaseW'(INHIBIT_CYCLES - 1);
    localparam logic [PhaseW-1:0] StartLast   = PhaseW'(START_HOLD - 1);
    localparam logic [ToW-1:0]    ToLast      = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [FiltW-1:0]  FiltLast    = FiltW'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StXfer,
        StAck,
        StWaitIdle
    } state_e;

    // Line index 0 is kclk, 1 is kdata.
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q [2];
    logic [FiltW-1:0] filt_cnt_d [2];
    logic             kclk_f, kdata_f, kclk_f_prev_q, fall;

    state_e            state_q, state_d;
    logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [9:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              kdata_dl_q, kdata_dl_d;
    logic              ack_err_r_q, ack_err_r_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              timeout_q, timeout_d;
    logic              timed_out;

    assign raw = {kdata_in, kclk_in};

    // Two-flop synchronizers; lines idle high so reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Stability filter: flip only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i]     = filt_q[i];
            filt_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (filt_cnt_q[i] == FiltLast) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + FiltW'(1);
                end
            end
        end
    end

    // Filter state and the previous filtered kclk used for fall detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q        <= 2'b11;
            kclk_f_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                filt_cnt_q[i] <= '0;
            end
        end else begin
            filt_q        <= filt_d;
            kclk_f_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                filt_cnt_q[i] <= filt_cnt_d[i];
            end
        end
    end

    assign kclk_f    = filt_q[0];
    assign kdata_f   = filt_q[1];
    assign fall      = kclk_f_prev_q & ~kclk_f;
    assign timed_out = (to_cnt_q == ToLast);

    // Transfer state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            to_cnt_q    <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            kdata_dl_q  <= 1'b0;
            ack_err_r_q <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            to_cnt_q    <= to_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            kdata_dl_q  <= kdata_dl_d;
            ack_err_r_q <= ack_err_r_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic; done/timeout_err are registered so they coincide with IDLE.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        to_cnt_d    = '0;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        kdata_dl_d  = kdata_dl_q;
        ack_err_r_d = ack_err_r_q;
        done_d      = 1'b0;
        ack_err_d   = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                phase_cnt_d = '0;
                kdata_dl_d  = 1'b0;
                if (bus.tx_valid) begin
                    // Shifted LSB first: D0..D7, odd parity, stop.
                    shift_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    bit_cnt_d = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (phase_cnt_q == InhibitLast) begin
                    phase_cnt_d = '0;
                    state_d     = StRts;
                end else begin
                    phase_cnt_d = phase_cnt_q + PhaseW'(1);
                end
            end
            StRts: begin
                if (phase_cnt_q == StartLast) begin
                    phase_cnt_d = '0;
                    kdata_dl_d  = 1'b1;  // start bit held as kclk is released
                    state_d     = StXfer;
                end else begin
                    phase_cnt_d = phase_cnt_q + PhaseW'(1);
                end
            end
            StXfer: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (fall) begin
                    kdata_dl_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (fall) begin
                    ack_err_r_d = kdata_f;  // device pulls kdata low to ACK
                    state_d     = StWaitIdle;
                end
            end
            StWaitIdle: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (kclk_f && kdata_f) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_err_r_q;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timeout abort; a completion in the same cycle takes precedence.
        if ((state_q == StXfer || state_q == StAck || state_q == StWaitIdle) &&
            timed_out && !done_d) begin
            state_d    = StIdle;
            kdata_dl_d = 1'b0;
            to_cnt_d   = '0;
            timeout_d  = 1'b1;
        end
    end

    // Pad enables and status outputs.
    always_comb begin
        kclk_drive_low  = (state_q == StInhibit) || (state_q == StRts);
        kdata_drive_low = (state_q == StRts) ||
                          (kdata_dl_q && (state_q == StXfer || state_q == StAck ||
                                          state_q == StWaitIdle));
        bus.tx_ready    = (state_q == StIdle);
        bus.busy        = (state_q != StIdle);
        bus.done        = done_q;
        bus.ack_err     = ack_err_q;
        bus.timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// checks them against a scoreboard of expected frames queued at each request.
module tb_ps2_host_tx;

    localparam int unsigned InhibitCycles = 20;
    localparam int unsigned StartHold     = 4;
    localparam int unsigned FilterCycles  = 3;
    localparam int unsigned TimeoutCycles = 3000;
    localparam int          HalfClk       = 20;  // device clock half-period in clk cycles

    typedef struct {
        logic [10:0] frame;
        logic        ack_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kclk_drive_low, kdata_drive_low;
    logic dev_kclk_low  = 1'b0;
    logic dev_kdata_low = 1'b0;
    logic kclk_pad, kdata_pad;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   to_cnt = 0;
    logic last_ack = 1'b0;
    exp_t sb_q [$];

    ps2_host_tx_if bus_if ();

    // Wired-AND open-drain lines with pull-ups.
    assign kclk_pad  = ~(kclk_drive_low | dev_kclk_low);
    assign kdata_pad = ~(kdata_drive_low | dev_kdata_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (InhibitCycles),
        .START_HOLD     (StartHold),
        .FILTER_CYCLES  (FilterCycles),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus_if.slave),
        .kclk_in         (kclk_pad),
        .kdata_in        (kdata_pad),
        .kclk_drive_low  (kclk_drive_low),
        .kdata_drive_low (kdata_drive_low)
    );

    always #5 clk = ~clk;

    // Event recorder for completion and timeout pulses.
    always @(negedge clk) begin
        if (bus_if.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            last_ack <= bus_if.ack_err;
        end
        if (bus_if.timeout_err === 1'b1) begin
            to_cnt <= to_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [7:0] d, input bit do_ack);
        exp_t e;
        int   n = 0;
        while (bus_if.tx_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        tick();
        bus_if.tx_valid = 1'b0;
        e.frame   = {1'b1, ~^d, d, 1'b0};
        e.ack_err = ~do_ack;
        sb_q.push_back(e);
    endtask

    // Counts kclk-only-low cycles, then both-low cycles, ending on first XFER cycle.
    task automatic measure_phases(output int inh, output int rts);
        inh = 0;
        rts = 0;
        while (kclk_drive_low === 1'b1 && kdata_drive_low === 1'b0 && inh < 200) begin
            inh++;
            tick();
        end
        while (kclk_drive_low === 1'b1 && kdata_drive_low === 1'b1 && rts < 200) begin
            rts++;
            tick();
        end
    endtask

    // Device: sample start, then 11 clocks sampling kdata on each rising edge.
    task automatic dev_frame(input bit do_ack, input bit glitch, output logic [10:0] frame);
        frame = '0;
        repeat (10) tick();
        frame[0] = kdata_pad;
        for (int i = 1; i <= 11; i++) begin
            dev_kclk_low = 1'b1;
            repeat (HalfClk) tick();
            dev_kclk_low = 1'b0;
            if (i <= 10) frame[i] = kdata_pad;
            if (i == 10 && do_ack) dev_kdata_low = 1'b1;
            if (i == 11) dev_kdata_low = 1'b0;
            if (glitch && i <= 9) begin
                repeat (8) tick();
                dev_kclk_low = 1'b1;
                repeat (2) tick();
                dev_kclk_low = 1'b0;
                repeat (HalfClk - 10) tick();
            end else begin
                repeat (HalfClk) tick();
            end
        end
    endtask

    task automatic wait_done(input int start, output bit got, output logic ack);
        int n = 0;
        while (done_cnt == start && n < 300) begin
            tick();
            n++;
        end
        got = (done_cnt != start);
        ack = last_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        repeat (5) tick();
        n_cmp += 7;
        if (bus_if.tx_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_tx_ready got %b want 1", bus_if.tx_ready);
        end
        if (bus_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got %b want 0", bus_if.busy);
        end
        if (kclk_drive_low !== 1'b0) begin
            n_bad++; $display("FAIL reset_kclk_dl got %b want 0", kclk_drive_low);
        end
        if (kdata_drive_low !== 1'b0) begin
            n_bad++; $display("FAIL reset_kdata_dl got %b want 0", kdata_drive_low);
        end
        if (bus_if.done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done got %b want 0", bus_if.done);
        end
        if (bus_if.ack_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_ack_err got %b want 0", bus_if.ack_err);
        end
        if (bus_if.timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_timeout got %b want 0", bus_if.timeout_err);
        end
        rst = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_send_ed();
        int          inh, rts, d0;
        logic [10:0] frame;
        bit          got;
        logic        ack;
        exp_t        e;
        request(8'hED, 1'b1);
        measure_phases(inh, rts);
        d0 = done_cnt;
        dev_frame(1'b1, 1'b0, frame);
        wait_done(d0, got, ack);
        e = sb_q.pop_front();
        n_cmp += 6;
        if (inh != InhibitCycles) begin
            n_bad++; $display("FAIL ed_inhibit got %0d want %0d", inh, InhibitCycles);
        end
        if (rts != StartHold) begin
            n_bad++; $display("FAIL ed_rts got %0d want %0d", rts, StartHold);
        end
        if (frame !== e.frame) begin
            n_bad++; $display("FAIL ed_frame got %b want %b", frame, e.frame);
        end
        if (!got) begin
            n_bad++; $display("FAIL ed_done got 0 want 1");
        end
        if (ack !== e.ack_err) begin
            n_bad++; $display("FAIL ed_ack_err got %b want %b", ack, e.ack_err);
        end
        if (bus_if.tx_ready !== 1'b1) begin
            n_bad++; $display("FAIL ed_ready got %b want 1", bus_if.tx_ready);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  bytes [2];
        int          inh, rts, d0;
        logic [10:0] frame;
        bit          got;
        logic        ack;
        exp_t        e;
        bytes[0] = 8'hFF;
        bytes[1] = 8'h01;
        for (int k = 0; k < 2; k++) begin
            request(bytes[k], 1'b1);
            measure_phases(inh, rts);
            d0 = done_cnt;
            dev_frame(1'b1, 1'b0, frame);
            wait_done(d0, got, ack);
            e = sb_q.pop_front();
            n_cmp += 3;
            if (frame !== e.frame) begin
                n_bad++; $display("FAIL parity_frame[%0d] got %b want %b", k, frame, e.frame);
            end
            if (!got) begin
                n_bad++; $display("FAIL parity_done[%0d] got 0 want 1", k);
            end
            if (ack !== e.ack_err) begin
                n_bad++; $display("FAIL parity_ack[%0d] got %b want %b", k, ack, e.ack_err);
            end
        end
    endtask

    task automatic test_no_ack();
        int          inh, rts, d0;
        logic [10:0] frame;
        bit          got;
        logic        ack;
        exp_t        e;
        request(8'hF4, 1'b0);
        measure_phases(inh, rts);
        d0 = done_cnt;
        dev_frame(1'b0, 1'b0, frame);
        wait_done(d0, got, ack);
        e = sb_q.pop_front();
        n_cmp += 4;
        if (frame !== e.frame) begin
            n_bad++; $display("FAIL noack_frame got %b want %b", frame, e.frame);
        end
        if (!got) begin
            n_bad++; $display("FAIL noack_done got 0 want 1");
        end
        if (ack !== e.ack_err) begin
            n_bad++; $display("FAIL noack_ack_err got %b want %b", ack, e.ack_err);
        end
        if ({kclk_drive_low, kdata_drive_low} !== 2'b00) begin
            n_bad++; $display("FAIL noack_lines got %b%b want 00", kclk_drive_low, kdata_drive_low);
        end
    endtask

    task automatic test_timeout();
        int inh, rts, d0, t0, n;
        request(8'h42, 1'b1);
        measure_phases(inh, rts);
        void'(sb_q.pop_front());
        d0 = done_cnt;
        t0 = to_cnt;
        n  = 0;
        while (bus_if.timeout_err !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        n_cmp += 4;
        if (n != TimeoutCycles) begin
            n_bad++; $display("FAIL timeout_latency got %0d want %0d", n, TimeoutCycles);
        end
        if ({kclk_drive_low, kdata_drive_low} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_lines got %b%b want 00", kclk_drive_low, kdata_drive_low);
        end
        if (bus_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_busy got %b want 0", bus_if.busy);
        end
        tick();
        if (done_cnt != d0 || to_cnt != t0 + 1) begin
            n_bad++;
            $display("FAIL timeout_pulses got done %0d to %0d want done %0d to %0d",
                     done_cnt - d0, to_cnt - t0, 0, 1);
        end
        repeat (20) tick();
    endtask

    task automatic test_mid_reset();
        int          inh, rts, d0;
        logic [10:0] frame;
        bit          got;
        logic        ack;
        exp_t        e;
        request(8'hA5, 1'b1);
        measure_phases(inh, rts);
        void'(sb_q.pop_front());
        repeat (10) tick();
        for (int i = 1; i <= 4; i++) begin
            dev_kclk_low = 1'b1;
            repeat (HalfClk) tick();
            dev_kclk_low = 1'b0;
            repeat (HalfClk) tick();
        end
        dev_kclk_low = 1'b1;
        rst = 1'b1;
        tick();
        n_cmp += 4;
        if (kclk_drive_low !== 1'b0) begin
            n_bad++; $display("FAIL midrst_kclk_dl got %b want 0", kclk_drive_low);
        end
        if (kdata_drive_low !== 1'b0) begin
            n_bad++; $display("FAIL midrst_kdata_dl got %b want 0", kdata_drive_low);
        end
        if (bus_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_busy got %b want 0", bus_if.busy);
        end
        if (bus_if.tx_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_ready got %b want 1", bus_if.tx_ready);
        end
        rst = 1'b0;
        dev_kclk_low = 1'b0;
        repeat (40) tick();

        request(8'h00, 1'b1);
        measure_phases(inh, rts);
        d0 = done_cnt;
        dev_frame(1'b1, 1'b0, frame);
        wait_done(d0, got, ack);
        e = sb_q.pop_front();
        n_cmp += 3;
        if (frame !== e.frame) begin
            n_bad++; $display("FAIL postrst_frame got %b want %b", frame, e.frame);
        end
        if (!got) begin
            n_bad++; $display("FAIL postrst_done got 0 want 1");
        end
        if (ack !== e.ack_err) begin
            n_bad++; $display("FAIL postrst_ack got %b want %b", ack, e.ack_err);
        end
    endtask

    task automatic test_glitch_busy();
        int          inh, rts, d0;
        logic [10:0] frame;
        bit          got, ready_seen, restart;
        logic        ack;
        exp_t        e;
        request(8'h3C, 1'b1);
        measure_phases(inh, rts);
        ready_seen = 1'b0;
        bus_if.tx_data  = 8'h99;
        bus_if.tx_valid = 1'b1;
        repeat (5) begin
            if (bus_if.tx_ready !== 1'b0) ready_seen = 1'b1;
            tick();
        end
        bus_if.tx_valid = 1'b0;
        d0 = done_cnt;
        dev_frame(1'b1, 1'b1, frame);
        wait_done(d0, got, ack);
        e = sb_q.pop_front();
        restart = 1'b0;
        repeat (40) begin
            tick();
            if (kclk_drive_low !== 1'b0) restart = 1'b1;
        end
        n_cmp += 6;
        if (ready_seen) begin
            n_bad++; $display("FAIL busy_ready got 1 want 0");
        end
        if (frame !== e.frame) begin
            n_bad++; $display("FAIL glitch_frame got %b want %b", frame, e.frame);
        end
        if (!got) begin
            n_bad++; $display("FAIL glitch_done got 0 want 1");
        end
        if (ack !== e.ack_err) begin
            n_bad++; $display("FAIL glitch_ack got %b want %b", ack, e.ack_err);
        end
        if (restart) begin
            n_bad++; $display("FAIL glitch_restart got 1 want 0");
        end
        if (sb_q.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover got %0d want 0", sb_q.size());
        end
    endtask

    initial begin
        bus_if.tx_data  = 8'h00;
        bus_if.tx_valid = 1'b0;
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_mid_reset();
        test_glitch_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard on the same kclk/kdata pair that the keyboard receive path listens on. It runs the full host request sequence: clock inhibit, request-to-send, 8 data bits with odd parity, stop bit, then device ACK. The pads are open-drain; this block only asserts "drive low" enables, and the top level ties the pads as pad = drive_low ? 0 : Z, with a pull-up.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles kclk is held low before request-to-send (100 us at 100 MHz).
START_HOLD, 200, clk cycles both lines are held low before kclk is released.
FILTER_CYCLES, 19, consecutive stable samples needed before a filtered line value changes.
TIMEOUT_CYCLES, 1500000, cycle limit from kclk release to transfer end (15 ms).

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous reset, active-high.
tx_data  in  8  command byte, sampled on handshake.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  high only in IDLE; a transfer starts when tx_valid & tx_ready.
kclk_in  in  1  raw kclk pad value (asynchronous).
kdata_in  in  1  raw kdata pad value (asynchronous).
kclk_drive_low  out  1  1 = pull kclk low.
kdata_drive_low  out  1  1 = pull kdata low.
busy  out  1  high from handshake until return to IDLE.
done  out  1  one-cycle pulse at normal transfer end.
ack_err  out  1  valid with done; 1 = device did not ACK.
timeout_err  out  1  one-cycle pulse on timeout abort; done stays 0.

Behaviour:
- Input conditioning:
  - 2-FF synchronizer on each line, then a stability filter.
  - kclk_f / kdata_f update only after FILTER_CYCLES identical consecutive samples.
  - Both filtered values reset to 1.
  - fall = kclk_f was 1 last cycle and is 0 now.
- Reset values: state IDLE, tx_ready=1, both drive_low=0, busy=0, done=0, ack_err=0, timeout_err=0, all counters 0.
- Reset mid-transfer releases both lines on the next edge.
- Handshake in IDLE:
  - Latch shift_reg = {1'b1 stop, ~^tx_data odd parity, tx_data}, 10 bits, shifted LSB first.
  - bit_cnt=0, go to INHIBIT.
  - tx_valid is ignored whenever tx_ready=0.
- INHIBIT: kclk_drive_low=1, kdata_drive_low=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: both drive_low=1 for START_HOLD cycles, then go to XFER.
- XFER:
  - kclk_drive_low=0 and kdata_drive_low=1 (start bit); timeout counter starts.
  - On each fall: kdata_drive_low <= ~shift_reg[0], shift right, bit_cnt++.
  - Falls 1-8 send D0-D7, fall 9 sends parity, fall 10 sends stop (line released).
  - After the 10th fall, go to ACK.
- ACK: on the next fall (11th), ack_err_r <= kdata_f, where 0 means ACK. Then go to WAIT_IDLE.
- WAIT_IDLE: when kclk_f=1 and kdata_f=1 in the same cycle, pulse done=1 with ack_err=ack_err_r for one cycle, then go to IDLE.
- Timeout:
  - In XFER, ACK or WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES: release both lines, pulse timeout_err for one cycle, go to IDLE.
  - If timeout and the completion condition occur in the same cycle, completion wins.
- busy is 1 in every state except IDLE, and drops in the same cycle that done or timeout_err pulses.
- Only falls of kclk_f are acted on; rising edges and glitches shorter than FILTER_CYCLES are ignored.
- While the host drives kclk low, kclk_f low does not count as a fall event. Falls are evaluated only in XFER and ACK.

Test Plan:
Bench parameters for all scenarios: INHIBIT_CYCLES=20, START_HOLD=4, FILTER_CYCLES=3, TIMEOUT_CYCLES=3000. The device model clocks at 40-cycle period, samples kdata on kclk rising edges, and ACKs by pulling kdata low across the 11th clock.
- Send 0xED -> kclk low 20 cycles, then both low 4 cycles; device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1 with ack_err=0, then tx_ready=1.
- Send 0xFF, then 0x01 -> parity bits sampled as 1 and 0; two done pulses, both with ack_err=0.
- Device omits ACK while sending 0xF4 -> done=1 with ack_err=1; lines released.
- Device never clocks after RTS -> timeout_err pulses exactly TIMEOUT_CYCLES cycles after kclk release; done=0; both drive_low=0.
- rst=1 asserted at the 5th fall of a transfer -> next cycle both drive_low=0, busy=0, tx_ready=1; a new 0x00 transfer then completes with parity 1.
- Inject 2-cycle kclk glitches during XFER, and assert tx_valid while busy -> no extra bits sent, second request ignored, byte received correctly.
